// File: rtl/mux_scan_capture.sv
// rtl/mux_scan_capture.sv - select-walking scan sequencer around a 16:1 mux stage
//
// Purpose:
//   Drives the select of a downstream combinational WIDTH:1 mux. It walks the
//   select from 0 to WIDTH-1 and samples the mux output once per select value.
//   The samples are assembled into a WIDTH-bit word. The mux plus this block
//   form a parallel-to-serial-to-parallel scan path. Each completed scan
//   updates data_out and raises valid for exactly one cycle.
//
// Parameters:
//   WIDTH   number of mux inputs scanned (must equal 2**SELW)
//   SELW    select width driven to the mux
//   SETTLE  extra wait cycles per select value before sampling (0..255)
//
// Ports:
//   clk       in   1      single clock, posedge
//   rst       in   1      asynchronous active-high reset
//   start     in   1      begin a scan; only honoured in IDLE
//   abort     in   1      synchronous abort back to IDLE
//   mux_f     in   1      output of the downstream mux
//   mux_s     out  SELW   registered select driven to the mux
//   busy      out  1      high while in SCAN or DONE
//   valid     out  1      one-cycle pulse; data_out holds the new word
//   data_out  out  WIDTH  last completed scan word; bit i = mux_f at select i

module mux_scan_capture #(
  parameter int WIDTH  = 16,
  parameter int SELW   = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mux_f,
  output logic [SELW-1:0]  mux_s,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]      SETTLE_CNT = SETTLE[7:0];
  localparam logic [SELW-1:0] LAST_SEL   = SELW'(WIDTH - 1);

  state_t           state, state_d;
  logic [7:0]       cnt, cnt_d;
  logic [SELW-1:0]  mux_s_d;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mux_s    <= '0;
      shadow   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      mux_s    <= mux_s_d;
      shadow   <= shadow_d;
      data_out <= data_d;
      valid    <= valid_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mux_s_d  = mux_s;
    shadow_d = shadow;
    data_d   = data_out;
    valid_d  = 1'b0;

    case (state)
      IDLE: begin
        // abort held in IDLE also masks start
        if (start && !abort) begin
          state_d = SCAN;
          mux_s_d = '0;
          cnt_d   = SETTLE_CNT;
        end
      end

      SCAN: begin
        if (abort) begin
          // abort wins over a capture in the same cycle; data_out untouched
          state_d = IDLE;
          mux_s_d = '0;
          cnt_d   = '0;
        end else if (cnt != '0) begin
          cnt_d = cnt - 8'd1;
        end else begin
          // mux_s has been stable for the whole cycle, so mux_f is settled
          shadow_d[mux_s] = mux_f;
          if (mux_s != LAST_SEL) begin
            mux_s_d = mux_s + 1'b1;
            cnt_d   = SETTLE_CNT;
          end else begin
            // the last bit is not yet in shadow, so merge it directly
            data_d            = shadow;
            data_d[WIDTH-1]   = mux_f;
            valid_d           = 1'b1;
            state_d           = DONE;
            mux_s_d           = '0;
          end
        end
      end

      DONE: begin
        // single-cycle state; start here is ignored, abort ends the same way
        state_d = IDLE;
        mux_s_d = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        mux_s_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_capture.sv
// tb/tb_mux_scan_capture.sv - directed self-checking bench for mux_scan_capture

module tb_mux_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;

  // instance 0: SETTLE=0
  logic        start0;
  logic [15:0] mux_in0;
  logic        mux_f0;
  logic [3:0]  mux_s0;
  logic        busy0, valid0;
  logic [15:0] data0;

  // instance 2: SETTLE=2
  logic        start2;
  logic [15:0] mux_in2;
  logic        mux_f2;
  logic [3:0]  mux_s2;
  logic        busy2, valid2;
  logic [15:0] data2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_f0 = mux_in0[mux_s0];
  assign mux_f2 = mux_in2[mux_s2];

  mux_scan_capture #(.WIDTH(16), .SELW(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .mux_f(mux_f0),
    .mux_s(mux_s0), .busy(busy0), .valid(valid0), .data_out(data0)
  );

  mux_scan_capture #(.WIDTH(16), .SELW(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .mux_f(mux_f2),
    .mux_s(mux_s2), .busy(busy2), .valid(valid2), .data_out(data2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // waits (bounded) for valid0; returns edge count since c0 reference
  task automatic wait_valid0(input int c0, output int lat);
    int k;
    lat = -1;
    for (k = 0; k < 200; k++) begin
      if (valid0) begin
        lat = cyc - c0 - 1;
        break;
      end
      tick(1);
    end
    if (lat < 0) check("valid0_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
  endtask

  initial begin
    int c0, c1, lat, vcount;
    logic seen;

    rst = 1'b1; abort = 1'b0; start0 = 1'b0; start2 = 1'b0;
    mux_in0 = 16'h0000; mux_in2 = 16'h0000;
    tick(2);
    check("rst_mux_s", {28'd0, mux_s0}, 32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_data",  {16'd0, data0}, 32'd0);
    check("rst_data2", {16'd0, data2}, 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: SETTLE=0 scan of A5C3
    mux_in0 = 16'hA5C3;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    check("t1_sel0", {28'd0, mux_s0}, 32'd0);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick(1);
      check("t1_sel", {28'd0, mux_s0}, k);
      check("t1_novalid", {31'd0, valid0}, 32'd0);
    end
    tick(1);
    check("t1_valid", {31'd0, valid0}, 32'd1);
    check("t1_data", {16'd0, data0}, 32'h0000A5C3);
    check("t1_sel_wrap", {28'd0, mux_s0}, 32'd0);
    check("t1_busy_done", {31'd0, busy0}, 32'd1);
    tick(1);
    check("t1_valid_low", {31'd0, valid0}, 32'd0);
    check("t1_busy_low", {31'd0, busy0}, 32'd0);

    // 2: SETTLE=2 scan of 8001
    mux_in2 = 16'h8001;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    check("t2_sel0", {28'd0, mux_s2}, 32'd0);
    for (int e = 1; e < 48; e++) begin
      tick(1);
      check("t2_sel", {28'd0, mux_s2}, e / 3);
      check("t2_novalid", {31'd0, valid2}, 32'd0);
    end
    tick(1);
    check("t2_valid", {31'd0, valid2}, 32'd1);
    check("t2_data", {16'd0, data2}, 32'h00008001);
    tick(1);
    check("t2_valid_low", {31'd0, valid2}, 32'd0);
    check("t2_busy_low", {31'd0, busy2}, 32'd0);

    // 3: held start, back-to-back scans 1234 then FFFF
    mux_in0 = 16'h1234;
    c0 = cyc;
    start0 = 1'b1;
    tick(1);
    wait_valid0(c0, lat);
    check("t3_lat", lat, 32'd16);
    check("t3_data1", {16'd0, data0}, 32'h00001234);
    c1 = cyc;
    mux_in0 = 16'hFFFF;
    tick(1);
    wait_valid0(c1, lat);
    check("t3_gap", lat + 1, 32'd18);
    check("t3_data2", {16'd0, data0}, 32'h0000FFFF);
    start0 = 1'b0;
    tick(3);
    check("t3_idle", {31'd0, busy0}, 32'd0);

    // 4: abort at mux_s=7 after a completed 00FF scan
    mux_in0 = 16'h00FF;
    c0 = cyc;
    pulse_start0();
    wait_valid0(c0, lat);
    check("t4_data_pre", {16'd0, data0}, 32'h000000FF);
    tick(2);
    mux_in0 = 16'h1111;
    pulse_start0();
    tick(7);
    check("t4_sel7", {28'd0, mux_s0}, 32'd7);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4_abort_busy", {31'd0, busy0}, 32'd0);
    check("t4_abort_sel", {28'd0, mux_s0}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (valid0) seen = 1'b1;
      tick(1);
    end
    check("t4_no_valid", {31'd0, seen}, 32'd0);
    check("t4_data_kept", {16'd0, data0}, 32'h000000FF);

    // 5: async reset mid-scan, then full scan
    mux_in0 = 16'h5A5A;
    pulse_start0();
    tick(10);
    check("t5_sel10", {28'd0, mux_s0}, 32'd10);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_sel", {28'd0, mux_s0}, 32'd0);
    check("t5_rst_busy", {31'd0, busy0}, 32'd0);
    check("t5_rst_data", {16'd0, data0}, 32'd0);
    check("t5_rst_valid", {31'd0, valid0}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    mux_in0 = 16'hC3A5;
    c0 = cyc;
    pulse_start0();
    wait_valid0(c0, lat);
    check("t5_lat", lat, 32'd16);
    check("t5_data", {16'd0, data0}, 32'h0000C3A5);
    tick(2);

    // 6: start pulses mid-scan and in DONE are ignored
    mux_in0 = 16'h0F0F;
    pulse_start0();
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid0) vcount++;
      start0 = (k == 5) || valid0;
      tick(1);
    end
    start0 = 1'b0;
    check("t6_one_valid", vcount, 32'd1);
    check("t6_data", {16'd0, data0}, 32'h00000F0F);
    check("t6_idle", {31'd0, busy0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
